// File: rtl/scope_ctrl.sv
// Scope capture/trigger controller: channel select, decimation, rising-edge trigger,
// 16-deep sample buffer drained one sample per hline. Optional auto trigger: SCOPE_AUTO_TRIG_EN.
module scope_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DECIM_W    = 8,
  parameter int AUTO_LINES = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ena,
  input  logic               in_valid,
  input  logic [3:0]         ch0,
  input  logic [3:0]         ch1,
  input  logic [3:0]         ch2,
  input  logic [3:0]         ch3,
  input  logic               btn_next,
  input  logic [DECIM_W-1:0] div,
  input  logic [3:0]         trig_level,
  input  logic               hline,
  output logic [3:0]         sample,
  output logic               s1,
  output logic               s2,
  output logic               s3,
  output logic               s4,
  output logic               triggered
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2+1)'(DEPTH-1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {ARMED, FILL, SHOW} state_t;

  state_t                state, state_nx;
  logic [1:0]            sel;
  logic                  btn_q;
  logic [DECIM_W-1:0]    dcnt;
  logic [3:0]            prev, cur;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [3:0]            mem [DEPTH];
  logic                  sel_chg, accept, crossing, trig_evt, push, pop;

  assign sel_chg  = btn_next && !btn_q;
  assign accept   = in_valid && (dcnt == div);
  assign crossing = (prev < trig_level) && (cur >= trig_level);

  always_comb begin
    cur = ch0;
    case (sel)
      2'd1:    cur = ch1;
      2'd2:    cur = ch2;
      2'd3:    cur = ch3;
      default: cur = ch0;
    endcase
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int LW = $clog2(AUTO_LINES + 1);
  localparam logic [LW-1:0] AUTO_MAX = LW'(AUTO_LINES);
  logic [LW-1:0] lcnt;
  logic          auto_hit;

  assign auto_hit = (lcnt == AUTO_MAX);
  assign trig_evt = accept && (crossing || auto_hit);

  // Saturates at AUTO_LINES so the next accepted sample fires regardless of level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lcnt <= '0;
    else if (ena) begin
      if (sel_chg || state_nx != ARMED || state != ARMED) lcnt <= '0;
      else if (hline && !auto_hit)                        lcnt <= lcnt + LW'(1);
    end
  end
`else
  assign trig_evt = accept && crossing;
`endif

  // Select change overrides everything: no push, no pop, back to ARMED.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    if (sel_chg) state_nx = ARMED;
    else begin
      case (state)
        ARMED: if (trig_evt) begin
          push     = 1'b1;
          state_nx = (count == CNT_LAST) ? SHOW : FILL;
        end
        FILL: if (accept) begin
          push = 1'b1;
          if (count == CNT_LAST) state_nx = SHOW;
        end
        SHOW: if (hline) begin
          pop = 1'b1;
          if (count == CNT_ONE) state_nx = ARMED;
        end
        default: state_nx = ARMED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  state <= ARMED;
    else if (ena)  state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_q  <= 1'b0;
      sel    <= 2'd0;
      dcnt   <= '0;
      prev   <= 4'hF;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sample <= 4'h0;
    end else if (ena) begin
      btn_q <= btn_next;
      if (in_valid) dcnt <= accept ? '0 : dcnt + DECIM_W'(1);
      if (sel_chg) begin
        sel    <= sel + 2'd1;
        prev   <= 4'hF;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) prev <= cur;
        if (push) begin
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
          count  <= count + CNT_ONE;
        end
        if (pop) begin
          sample <= mem[rd_ptr];
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
          count  <= count - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ena && push) mem[wr_ptr] <= cur;
  end

  assign s1        = (sel == 2'd0);
  assign s2        = (sel == 2'd1);
  assign s3        = (sel == 2'd2);
  assign s4        = (sel == 2'd3);
  assign triggered = (state != ARMED);

endmodule

// File: tb/tb_scope_ctrl.sv
// Directed bench for scope_ctrl: trigger/fill, drain, decimation, select flush, auto trigger.
module tb_scope_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
  logic       btn_next = 1'b0;
  logic [7:0] div = '0;
  logic [3:0] trig_level = 4'd8;
  logic       hline = 1'b0;
  logic [3:0] sample;
  logic       s1, s2, s3, s4, triggered;

  int pass_cnt = 0;
  int total    = 0;

  scope_ctrl #(.DEPTH_LOG2(4), .DECIM_W(8), .AUTO_LINES(4)) dut (
    .clock(clock), .reset_n(reset_n), .ena(ena), .in_valid(in_valid),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .btn_next(btn_next),
    .div(div), .trig_level(trig_level), .hline(hline),
    .sample(sample), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .triggered(triggered)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [3:0] a, input logic [3:0] b);
    ch0 = a; ch1 = b; ch2 = b; ch3 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_hline();
    hline = 1'b1;
    tick();
    hline = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({s1, s2, s3, s4} !== 4'b1000) $display("FAIL reset_sel got %b want 1000", {s1, s2, s3, s4});
    else pass_cnt++;
    total++;
    if (sample !== 4'h0) $display("FAIL reset_sample got %0d want 0", sample);
    else pass_cnt++;
    total++;
    if (triggered !== 1'b0) $display("FAIL reset_trig got %b want 0", triggered);
    else pass_cnt++;
  endtask

  task automatic test_trigger_fill();
    div = 8'd0; trig_level = 4'd8;
    for (int v = 0; v < 8; v++) feed(4'(v), 4'd0);
    total++;
    if (triggered !== 1'b0) $display("FAIL pre_trigger got %b want 0", triggered);
    else pass_cnt++;
    feed(4'd8, 4'd0);
    total++;
    if (triggered !== 1'b1) $display("FAIL trigger_on_8 got %b want 1", triggered);
    else pass_cnt++;
    for (int v = 9; v < 24; v++) feed(4'(v), 4'd0);
    total++;
    if (triggered !== 1'b1) $display("FAIL full_show got %b want 1", triggered);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    total++;
    if (sample !== 4'h0) $display("FAIL sample_hold_fill got %0d want 0", sample);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      pulse_hline();
      total++;
      if (sample !== 4'((8 + i) % 16)) $display("FAIL drain[%0d] got %0d want %0d", i, sample, (8 + i) % 16);
      else pass_cnt++;
    end
    total++;
    if (triggered !== 1'b0) $display("FAIL drain_armed got %b want 0", triggered);
    else pass_cnt++;
    pulse_hline();
    total++;
    if (sample !== 4'd7) $display("FAIL hline_armed_hold got %0d want 7", sample);
    else pass_cnt++;
  endtask

  task automatic test_decim();
    do_reset();
    div = 8'd2; trig_level = 4'd8;
    for (int v = 0; v < 54; v++) feed(4'(v), 4'd0);
    total++;
    if (triggered !== 1'b1) $display("FAIL decim_trig got %b want 1", triggered);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      pulse_hline();
      total++;
      if (sample !== 4'((8 + 3 * i) % 16)) $display("FAIL decim[%0d] got %0d want %0d", i, sample, (8 + 3 * i) % 16);
      else pass_cnt++;
    end
    total++;
    if (triggered !== 1'b0) $display("FAIL decim_armed got %b want 0", triggered);
    else pass_cnt++;
  endtask

  task automatic test_sel_change();
    do_reset();
    div = 8'd0; trig_level = 4'd8;
    for (int v = 0; v < 13; v++) feed(4'(v), 4'd0);
    total++;
    if (triggered !== 1'b1) $display("FAIL sel_prefill got %b want 1", triggered);
    else pass_cnt++;
    btn_next = 1'b1;
    tick();
    total++;
    if ({s1, s2, s3, s4} !== 4'b0100) $display("FAIL sel_onehot got %b want 0100", {s1, s2, s3, s4});
    else pass_cnt++;
    total++;
    if (triggered !== 1'b0) $display("FAIL sel_flush got %b want 0", triggered);
    else pass_cnt++;
    btn_next = 1'b0;
    tick();
    feed(4'd5, 4'd9);
    total++;
    if (triggered !== 1'b0) $display("FAIL sel_prevF got %b want 0", triggered);
    else pass_cnt++;
    feed(4'd5, 4'd2);
    feed(4'd5, 4'd8);
    total++;
    if (triggered !== 1'b1) $display("FAIL sel_retrig got %b want 1", triggered);
    else pass_cnt++;
    for (int v = 9; v < 24; v++) feed(4'd5, 4'(v));
    for (int i = 0; i < 16; i++) begin
      pulse_hline();
      total++;
      if (sample !== 4'((8 + i) % 16)) $display("FAIL ch1_drain[%0d] got %0d want %0d", i, sample, (8 + i) % 16);
      else pass_cnt++;
    end
  endtask

  task automatic test_sel_wins();
    feed(4'd0, 4'd2);
    feed(4'd0, 4'd8);
    for (int v = 9; v < 24; v++) feed(4'd0, 4'(v));
    pulse_hline();
    total++;
    if (sample !== 4'd8) $display("FAIL wins_pop got %0d want 8", sample);
    else pass_cnt++;
    ena = 1'b0;
    pulse_hline();
    ena = 1'b1;
    total++;
    if (sample !== 4'd8) $display("FAIL ena_hold got %0d want 8", sample);
    else pass_cnt++;
    hline = 1'b1; btn_next = 1'b1;
    tick();
    hline = 1'b0; btn_next = 1'b0;
    total++;
    if (sample !== 4'd8) $display("FAIL wins_nopop got %0d want 8", sample);
    else pass_cnt++;
    total++;
    if ({triggered, s1, s2, s3, s4} !== 5'b00010) $display("FAIL wins_state got %b want 00010", {triggered, s1, s2, s3, s4});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midfill();
    feed(4'd0, 4'd2);
    feed(4'd0, 4'd8);
    feed(4'd0, 4'd9);
    total++;
    if (triggered !== 1'b1) $display("FAIL midfill_pre got %b want 1", triggered);
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #2;
    total++;
    if ({triggered, s1, s2, s3, s4, sample} !== 9'b0_1000_0000)
      $display("FAIL async_reset got %b want 010000000", {triggered, s1, s2, s3, s4, sample});
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_auto();
    do_reset();
    div = 8'd0; trig_level = 4'd8;
    ch0 = 4'd3;
    for (int i = 0; i < 4; i++) pulse_hline();
    feed(4'd3, 4'd3);
`ifdef SCOPE_AUTO_TRIG_EN
    total++;
    if (triggered !== 1'b1) $display("FAIL auto_trig got %b want 1", triggered);
    else pass_cnt++;
    for (int v = 0; v < 15; v++) feed(4'd3, 4'd3);
    for (int i = 0; i < 16; i++) begin
      pulse_hline();
      total++;
      if (sample !== 4'd3) $display("FAIL auto_drain[%0d] got %0d want 3", i, sample);
      else pass_cnt++;
    end
    total++;
    if (triggered !== 1'b0) $display("FAIL auto_armed got %b want 0", triggered);
    else pass_cnt++;
`else
    total++;
    if (triggered !== 1'b0) $display("FAIL no_auto got %b want 0", triggered);
    else pass_cnt++;
    for (int v = 0; v < 20; v++) feed(4'd3, 4'd3);
    total++;
    if (triggered !== 1'b0) $display("FAIL no_auto_long got %b want 0", triggered);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_trigger_fill();
    test_drain();
    test_decim();
    test_sel_change();
    test_sel_wins();
    test_reset_midfill();
    test_auto();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/scope_ctrl.md
Name: scope_ctrl

Overview:
- Capture and trigger controller that feeds the VGA scope renderer.
- Selects one of four 4-bit input channels and decimates it.
- Waits for a rising-edge trigger, then fills a small sample buffer.
- Drains the buffer one sample per render line strobe (hline) into the renderer's sample input, and drives the s1..s4 channel indicators.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth. Depth = 16 entries of 4 bits.
- DECIM_W, 8, width of the decimation divider and counter.
- AUTO_LINES, 64, hline count before an automatic trigger (optional feature only).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low, all state holds
- in_valid  in  1  one-cycle strobe; ch0..ch3 are valid this cycle
- ch0  in  4  channel 0 data
- ch1  in  4  channel 1 data
- ch2  in  4  channel 2 data
- ch3  in  4  channel 3 data
- btn_next  in  1  channel-advance button, synchronous level
- div  in  DECIM_W  decimation: accept 1 of every div+1 valid samples
- trig_level  in  4  trigger threshold
- hline  in  1  render line strobe from the VGA timing block
- sample  out  4  current sample to the renderer
- s1  out  1  channel 0 selected
- s2  out  1  channel 1 selected
- s3  out  1  channel 2 selected
- s4  out  1  channel 3 selected
- triggered  out  1  high in FILL and SHOW

Behaviour:
- Clock and reset: single clock `clock`; reset_n is asynchronous, active-low. All registers update only when ena=1.
- Reset values:
  - sample=0, sel=0 (so s1=1, s2=s3=s4=0), triggered=0
  - state=ARMED, decimation counter=0, prev=4'hF
  - buffer pointers and count=0
- Channel select: btn_next is registered; a rising edge advances sel 0→1→2→3→0. s1..s4 = one-hot of sel.
  - A select change in any state flushes the buffer (count=0, pointers=0), loads prev=4'hF, and forces ARMED on the next cycle.
  - sample holds its value through a flush.
- Decimation: on in_valid, if the counter equals div, the sample is "accepted" and the counter goes to 0; otherwise the counter increments. div=0 accepts every valid. The counter runs in all states.
- Accepted value: cur = ch[sel]. prev <= cur on every accepted sample, in all states.
- Trigger event: an accepted sample with prev < trig_level and cur >= trig_level. Unsigned 4-bit compare.
- State machine:
  - ARMED: no pops. On a trigger event, push cur and go to FILL.
  - FILL: push every accepted sample. When count reaches 2^DEPTH_LOG2, go to SHOW in the same cycle as the final push. No push ever occurs while full.
  - SHOW: on hline, pop the head into sample (sample updates the cycle after the strobe, one-cycle latency). Pops on empty are impossible. When the pop empties the buffer, go to ARMED. Accepted samples are ignored but still update prev.
- hline in ARMED or FILL: ignored; sample holds.
- Simultaneous btn edge and hline or trigger: the select change wins. Flush, no pop, no push.
- Pointers wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits.
- triggered = (state != ARMED).
- Buffer: register array. Read is combinational from rd_ptr; sample is registered.
- reset_n low mid-FILL or mid-SHOW: immediate return to reset values. Buffer contents need not clear.

Optional Feature:
- Macro SCOPE_AUTO_TRIG_EN.
- Defined:
  - A line counter counts hline strobes while in ARMED. It clears on leaving ARMED and on a select change.
  - At AUTO_LINES strobes, the next accepted sample is treated as a trigger event even if there is no level crossing.
- Undefined: no counter logic; ARMED waits indefinitely for a real crossing.

Test Plan:
- Reset: reset_n=0 then 1 → sample=0, s1=1, s2..s4=0, triggered=0.
- Trigger and fill: div=0, trig_level=8, sel=0, ch0 ramps 0..15 with in_valid every cycle.
  - Trigger fires on value 8 and triggered rises.
  - 16 pushes capture 8..15,0..7 (ramp wraps).
  - State is SHOW after the 16th push.
- Drain: 16 hline pulses in SHOW → sample sequence 8,9,…,15,0,…,7, each one cycle after its strobe. After the last, triggered=0 (ARMED).
- Decimation: div=2, in_valid every cycle, ramp input → every 3rd value accepted. Buffer holds 8,11,14,1,… (mod 16).
- Channel change mid-FILL: after 5 pushes, pulse btn_next → s2=1, triggered=0. The next fill is from ch1 only, with a fresh trigger required (prev=F).
- With SCOPE_AUTO_TRIG_EN, AUTO_LINES=4: constant input 3, trig_level=8, 4 hline pulses in ARMED → the next accepted sample triggers and the buffer fills with 3s. Without the macro, triggered stays 0.
